mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 28 ++
 rtl/mem_stage_load_align.sv | 43 ++++
 rtl/mem_stage.sv | 115 +++++++++++
 tb/tb_mem_stage.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage definitions: bus widths and the EX->MEM field layout.
// The EX->MEM bus is packed MSB first in the order of the struct below.
package mem_stage_pkg;

    localparam int EX_TO_MEM_W = 109;
    localparam int MEM_TO_WB_W = 70;
    localparam int RF_ZIP_W    = 38;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic        ld_b;
        logic        ld_bu;
        logic        ld_h;
        logic        ld_hu;
        logic        ld_w;
        logic        res_from_mul;
        logic        res_from_div;
        logic [31:0] div_result;
    } ex_to_mem_t;

    function automatic logic is_load(input ex_to_mem_t bus);
        return bus.ld_b | bus.ld_bu | bus.ld_h | bus.ld_hu | bus.ld_w;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load alignment: picks the byte/half/word addressed by addr
// out of the SRAM read word and sign- or zero-extends it.
module load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic        ld_b,
    input  logic        ld_bu,
    input  logic        ld_h,
    input  logic        ld_hu,
    input  logic        ld_w,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        // Halfword selection ignores addr[0]; misaligned halves are not trapped.
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        load_data = 32'd0;
        if (ld_b) begin
            load_data = {{24{byte_sel[7]}}, byte_sel};
        end else if (ld_bu) begin
            load_data = {24'd0, byte_sel};
        end else if (ld_h) begin
            load_data = {{16{half_sel[15]}}, half_sel};
        end else if (ld_hu) begin
            load_data = {16'd0, half_sel};
        end else if (ld_w) begin
            load_data = rdata;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, aligns load data, picks the result.
// Optional MEM_RDATA_BUF_EN keeps the first-cycle SRAM word for stalled loads.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int EX_TO_MEM_WIDTH = EX_TO_MEM_W,
    parameter int MEM_TO_WB_WIDTH = MEM_TO_WB_W
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       mem_allowin,
    input  logic                       ex_to_mem_valid,
    input  logic [EX_TO_MEM_WIDTH-1:0] ex_to_mem_wire,
    input  logic                       wb_allowin,
    output logic                       mem_to_wb_valid,
    output logic [MEM_TO_WB_WIDTH-1:0] mem_to_wb_wire,
    input  logic [31:0]                mul_result,
    input  logic [31:0]                data_sram_rdata,
    output logic [RF_ZIP_W-1:0]        mem_rf_zip
);

    logic                       mem_valid_q, mem_valid_d;
    logic [EX_TO_MEM_WIDTH-1:0] payload_q, payload_d;
    logic                       mem_ready_go;
    logic                       ld_any;
    ex_to_mem_t                 mem_bus;
    logic [31:0]                load_rdata;
    logic [31:0]                load_data;
    logic [31:0]                final_result;

    assign mem_ready_go    = 1'b1;
    assign mem_allowin     = ~mem_valid_q | (mem_ready_go & wb_allowin);
    assign mem_to_wb_valid = mem_valid_q & mem_ready_go;
    assign mem_bus         = ex_to_mem_t'(payload_q);
    assign ld_any          = is_load(mem_bus);

    always_comb begin
        mem_valid_d = mem_valid_q;
        payload_d   = payload_q;
        if (mem_allowin) begin
            mem_valid_d = ex_to_mem_valid;
        end
        if (ex_to_mem_valid && mem_allowin) begin
            payload_d = ex_to_mem_wire;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q <= 1'b0;
        end else begin
            mem_valid_q <= mem_valid_d;
        end
        payload_q <= payload_d;
    end

`ifdef MEM_RDATA_BUF_EN
    logic        rbuf_valid_q, rbuf_valid_d;
    logic [31:0] rbuf_data_q, rbuf_data_d;
    logic        handoff;

    assign handoff = mem_to_wb_valid & wb_allowin;

    // Capture only in the first MEM cycle of a load; later stall cycles reuse it.
    always_comb begin
        rbuf_valid_d = rbuf_valid_q;
        rbuf_data_d  = rbuf_data_q;
        if (handoff) begin
            rbuf_valid_d = 1'b0;
        end else if (mem_valid_q && ld_any && !rbuf_valid_q) begin
            rbuf_valid_d = 1'b1;
            rbuf_data_d  = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rbuf_valid_q <= 1'b0;
        end else begin
            rbuf_valid_q <= rbuf_valid_d;
        end
        rbuf_data_q <= rbuf_data_d;
    end

    assign load_rdata = rbuf_valid_q ? rbuf_data_q : data_sram_rdata;
`else
    assign load_rdata = data_sram_rdata;
`endif

    load_align u_load_align (
        .rdata     (load_rdata),
        .addr      (mem_bus.alu_result[1:0]),
        .ld_b      (mem_bus.ld_b),
        .ld_bu     (mem_bus.ld_bu),
        .ld_h      (mem_bus.ld_h),
        .ld_hu     (mem_bus.ld_hu),
        .ld_w      (mem_bus.ld_w),
        .load_data (load_data)
    );

    always_comb begin
        final_result = mem_bus.alu_result;
        if (ld_any) begin
            final_result = load_data;
        end else if (mem_bus.res_from_mul) begin
            final_result = mul_result;
        end else if (mem_bus.res_from_div) begin
            final_result = mem_bus.div_result;
        end
    end

    assign mem_to_wb_wire = {mem_bus.rf_we, mem_bus.rf_waddr, mem_bus.pc, final_result};
    assign mem_rf_zip     = {mem_bus.rf_we & mem_valid_q, mem_bus.rf_waddr, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: handshake, load alignment, result priority,
// stall hold and reset behaviour.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_allowin;
    logic         ex_to_mem_valid;
    logic [108:0] ex_to_mem_wire;
    logic         wb_allowin;
    logic         mem_to_wb_valid;
    logic [69:0]  mem_to_wb_wire;
    logic [31:0]  mul_result;
    logic [31:0]  data_sram_rdata;
    logic [37:0]  mem_rf_zip;

    int checks   = 0;
    int failures = 0;

    localparam logic [4:0] LD_NONE = 5'b00000;
    localparam logic [4:0] LD_B    = 5'b10000;
    localparam logic [4:0] LD_BU   = 5'b01000;
    localparam logic [4:0] LD_H    = 5'b00100;
    localparam logic [4:0] LD_HU   = 5'b00010;
    localparam logic [4:0] LD_W    = 5'b00001;

    localparam int NLD = 9;
    localparam logic [4:0]  T_LD   [NLD] = '{LD_B, LD_BU, LD_B, LD_HU, LD_H, LD_H, LD_H, LD_HU, LD_W};
    localparam logic [31:0] T_ADDR [NLD] = '{32'h1003, 32'h1002, 32'h1000, 32'h1002, 32'h1002,
                                             32'h1000, 32'h1001, 32'h1003, 32'h1000};
    localparam logic [31:0] T_RD   [NLD] = '{32'h80FF_1234, 32'h80FF_1234, 32'h80FF_1234,
                                             32'h8001_7FFF, 32'h8001_7FFF, 32'h8001_7FFF,
                                             32'h8001_7FFF, 32'h8001_7FFF, 32'hDEAD_BEEF};
    localparam logic [31:0] T_EXP  [NLD] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'h0000_0034,
                                             32'h0000_8001, 32'hFFFF_8001, 32'h0000_7FFF,
                                             32'h0000_7FFF, 32'h0000_8001, 32'hDEAD_BEEF};

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .mem_allowin     (mem_allowin),
        .ex_to_mem_valid (ex_to_mem_valid),
        .ex_to_mem_wire  (ex_to_mem_wire),
        .wb_allowin      (wb_allowin),
        .mem_to_wb_valid (mem_to_wb_valid),
        .mem_to_wb_wire  (mem_to_wb_wire),
        .mul_result      (mul_result),
        .data_sram_rdata (data_sram_rdata),
        .mem_rf_zip      (mem_rf_zip)
    );

    always #5 clk = ~clk;

    function automatic logic [108:0] make_ex(input logic we, input logic [4:0] waddr,
                                             input logic [31:0] pc, input logic [31:0] alu,
                                             input logic [4:0] ld, input logic mul,
                                             input logic dv, input logic [31:0] div_res);
        return {we, waddr, pc, alu, ld, mul, dv, div_res};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ex_to_mem_valid = 1'b0;
        wb_allowin = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (mem_to_wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", mem_to_wb_valid);
        end
        checks++;
        if (mem_allowin !== 1'b1) begin
            failures++;
            $display("FAIL reset_allowin got=%b exp=1", mem_allowin);
        end
        checks++;
        if (mem_rf_zip[37] !== 1'b0) begin
            failures++;
            $display("FAIL reset_zip_we got=%b exp=0", mem_rf_zip[37]);
        end
    endtask

    task automatic test_loads();
        logic [31:0] pc;
        for (int i = 0; i < NLD; i++) begin
            pc = 32'h1C00_0000 + 32'(i * 4);
            ex_to_mem_valid = 1'b1;
            ex_to_mem_wire  = make_ex(1'b1, 5'd3, pc, T_ADDR[i], T_LD[i], 1'b0, 1'b0, 32'h0);
            wb_allowin = 1'b1;
            step();
            ex_to_mem_valid = 1'b0;
            data_sram_rdata = T_RD[i];
            #1;
            checks++;
            if (mem_to_wb_valid !== 1'b1) begin
                failures++;
                $display("FAIL load%0d_valid got=%b exp=1", i, mem_to_wb_valid);
            end
            checks++;
            if (mem_to_wb_wire !== {1'b1, 5'd3, pc, T_EXP[i]}) begin
                failures++;
                $display("FAIL load%0d_wire got=%h exp=%h", i, mem_to_wb_wire, {1'b1, 5'd3, pc, T_EXP[i]});
            end
        end
        step();
        checks++;
        if (mem_to_wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL load_drain_valid got=%b exp=0", mem_to_wb_valid);
        end
    endtask

    task automatic test_result_select();
        // div result wins over alu
        ex_to_mem_valid = 1'b1;
        ex_to_mem_wire  = make_ex(1'b1, 5'd5, 32'h1C00_0100, 32'h99, LD_NONE, 1'b0, 1'b1, 32'h7);
        mul_result = 32'h0000_0006;
        step();
        ex_to_mem_valid = 1'b0;
        #1;
        checks++;
        if (mem_to_wb_wire[31:0] !== 32'h7) begin
            failures++;
            $display("FAIL div_result got=%h exp=00000007", mem_to_wb_wire[31:0]);
        end
        checks++;
        if (mem_rf_zip !== {1'b1, 5'd5, 32'h7}) begin
            failures++;
            $display("FAIL div_zip got=%h exp=%h", mem_rf_zip, {1'b1, 5'd5, 32'h7});
        end
        // mul wins over div
        ex_to_mem_valid = 1'b1;
        ex_to_mem_wire  = make_ex(1'b1, 5'd6, 32'h1C00_0104, 32'h99, LD_NONE, 1'b1, 1'b1, 32'h7);
        step();
        ex_to_mem_valid = 1'b0;
        #1;
        checks++;
        if (mem_to_wb_wire[31:0] !== 32'h6) begin
            failures++;
            $display("FAIL mul_over_div got=%h exp=00000006", mem_to_wb_wire[31:0]);
        end
        // load wins over mul
        ex_to_mem_valid = 1'b1;
        ex_to_mem_wire  = make_ex(1'b0, 5'd8, 32'h1C00_0108, 32'h2000, LD_W, 1'b1, 1'b0, 32'h0);
        step();
        ex_to_mem_valid = 1'b0;
        data_sram_rdata = 32'h1357_9BDF;
        #1;
        checks++;
        if (mem_to_wb_wire[31:0] !== 32'h1357_9BDF) begin
            failures++;
            $display("FAIL load_over_mul got=%h exp=13579bdf", mem_to_wb_wire[31:0]);
        end
        checks++;
        if (mem_rf_zip[37] !== 1'b0) begin
            failures++;
            $display("FAIL zip_we_off got=%b exp=0", mem_rf_zip[37]);
        end
        // plain alu
        ex_to_mem_valid = 1'b1;
        ex_to_mem_wire  = make_ex(1'b1, 5'd9, 32'h1C00_010C, 32'hABCD_0123, LD_NONE, 1'b0, 1'b0, 32'h5);
        step();
        ex_to_mem_valid = 1'b0;
        #1;
        checks++;
        if (mem_to_wb_wire[31:0] !== 32'hABCD_0123) begin
            failures++;
            $display("FAIL alu_result got=%h exp=abcd0123", mem_to_wb_wire[31:0]);
        end
        step();
        checks++;
        if (mem_rf_zip[37] !== 1'b0) begin
            failures++;
            $display("FAIL zip_idle_we got=%b exp=0", mem_rf_zip[37]);
        end
    endtask

    task automatic test_back_to_back();
        wb_allowin = 1'b1;
        ex_to_mem_valid = 1'b1;
        ex_to_mem_wire  = make_ex(1'b1, 5'd10, 32'h1C00_0200, 32'h55, LD_NONE, 1'b1, 1'b0, 32'h0);
        step();
        mul_result = 32'h0000_0006;
        ex_to_mem_wire = make_ex(1'b1, 5'd11, 32'h1C00_0204, 32'h10, LD_NONE, 1'b0, 1'b0, 32'h0);
        #1;
        checks++;
        if (mem_to_wb_valid !== 1'b1 || mem_to_wb_wire !== {1'b1, 5'd10, 32'h1C00_0200, 32'h6}) begin
            failures++;
            $display("FAIL b2b_first got=%b/%h exp=1/%h", mem_to_wb_valid, mem_to_wb_wire,
                     {1'b1, 5'd10, 32'h1C00_0200, 32'h6});
        end
        checks++;
        if (mem_allowin !== 1'b1) begin
            failures++;
            $display("FAIL b2b_allowin got=%b exp=1", mem_allowin);
        end
        step();
        ex_to_mem_valid = 1'b0;
        mul_result = 32'h0000_0BAD;
        #1;
        checks++;
        if (mem_to_wb_valid !== 1'b1 || mem_to_wb_wire !== {1'b1, 5'd11, 32'h1C00_0204, 32'h10}) begin
            failures++;
            $display("FAIL b2b_second got=%b/%h exp=1/%h", mem_to_wb_valid, mem_to_wb_wire,
                     {1'b1, 5'd11, 32'h1C00_0204, 32'h10});
        end
        step();
        checks++;
        if (mem_to_wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_dup got=%b exp=0", mem_to_wb_valid);
        end
    endtask

    task automatic test_stall();
        wb_allowin = 1'b1;
        ex_to_mem_valid = 1'b1;
        ex_to_mem_wire  = make_ex(1'b1, 5'd7, 32'h1C00_0300, 32'h2000, LD_W, 1'b0, 1'b0, 32'h0);
        step();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_wire  = make_ex(1'b1, 5'd12, 32'h1C00_0304, 32'h77, LD_NONE, 1'b0, 1'b0, 32'h0);
        data_sram_rdata = 32'hDEAD_BEEF;
        wb_allowin = 1'b0;
        #1;
        checks++;
        if (mem_allowin !== 1'b0 || mem_to_wb_wire[31:0] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL stall_first got=%b/%h exp=0/deadbeef", mem_allowin, mem_to_wb_wire[31:0]);
        end
        for (int c = 0; c < 3; c++) begin
            step();
`ifdef MEM_RDATA_BUF_EN
            data_sram_rdata = 32'h0;
`endif
            #1;
            checks++;
            if (mem_allowin !== 1'b0 || mem_to_wb_valid !== 1'b1 ||
                mem_to_wb_wire !== {1'b1, 5'd7, 32'h1C00_0300, 32'hDEAD_BEEF}) begin
                failures++;
                $display("FAIL stall_hold%0d got=%b/%b/%h exp=0/1/%h", c, mem_allowin, mem_to_wb_valid,
                         mem_to_wb_wire, {1'b1, 5'd7, 32'h1C00_0300, 32'hDEAD_BEEF});
            end
        end
        wb_allowin = 1'b1;
        #1;
        checks++;
        if (mem_allowin !== 1'b1 || mem_to_wb_wire[31:0] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL stall_release got=%b/%h exp=1/deadbeef", mem_allowin, mem_to_wb_wire[31:0]);
        end
        step();
        ex_to_mem_valid = 1'b0;
        #1;
        checks++;
        if (mem_to_wb_valid !== 1'b1 || mem_to_wb_wire !== {1'b1, 5'd12, 32'h1C00_0304, 32'h77}) begin
            failures++;
            $display("FAIL stall_next got=%b/%h exp=1/%h", mem_to_wb_valid, mem_to_wb_wire,
                     {1'b1, 5'd12, 32'h1C00_0304, 32'h77});
        end
        step();
    endtask

    task automatic test_reset_stall();
        wb_allowin = 1'b1;
        ex_to_mem_valid = 1'b1;
        ex_to_mem_wire  = make_ex(1'b1, 5'd13, 32'h1C00_0400, 32'h3000, LD_W, 1'b0, 1'b0, 32'h0);
        step();
        ex_to_mem_valid = 1'b0;
        data_sram_rdata = 32'h1234_5678;
        wb_allowin = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (mem_to_wb_valid !== 1'b0 || mem_rf_zip[37] !== 1'b0 || mem_allowin !== 1'b1) begin
            failures++;
            $display("FAIL rst_stall got=%b/%b/%b exp=0/0/1", mem_to_wb_valid, mem_rf_zip[37], mem_allowin);
        end
        wb_allowin = 1'b1;
        ex_to_mem_valid = 1'b1;
        ex_to_mem_wire  = make_ex(1'b1, 5'd14, 32'h1C00_0404, 32'h3004, LD_W, 1'b0, 1'b0, 32'h0);
        step();
        ex_to_mem_valid = 1'b0;
        data_sram_rdata = 32'hCAFE_F00D;
        #1;
        checks++;
        if (mem_to_wb_wire[31:0] !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL rst_buf_clear got=%h exp=cafef00d", mem_to_wb_wire[31:0]);
        end
        step();
    endtask

    initial begin
        reset = 1'b1;
        ex_to_mem_valid = 1'b0;
        ex_to_mem_wire = '0;
        wb_allowin = 1'b1;
        mul_result = '0;
        data_sram_rdata = '0;
        test_reset();
        test_loads();
        test_result_select();
        test_back_to_back();
        test_stall();
        test_reset_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
